// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 CTR framing path.
package aes_pkg;

    localparam int AES_BLOCK_SIZE  = 128;
    localparam int AES_KEY_LENGTH  = 256;
    localparam int AES_BLOCK_BYTES = AES_BLOCK_SIZE / 8;
    localparam logic [AES_BLOCK_BYTES-1:0] KEEP_FULL = '1;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_KEY_LO = 5'b00010,
        ST_KEY_HI = 5'b00100,
        ST_CTR    = 5'b01000,
        ST_DATA   = 5'b10000
    } framer_state_t;

endpackage

// File: rtl/aes_axis_reg_slice.sv
// One-entry AXI-Stream pipeline register: accepted beat appears downstream one cycle later,
// and the entry can be refilled in the same cycle it drains.
module aes_axis_reg_slice
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_BLOCK_SIZE,
    parameter int KEEP_W = AES_BLOCK_BYTES
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_last
);

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [KEEP_W-1:0] keep_p1;
    logic              last_p1;

    assign s_ready = !vld_p1 || m_ready;

    // p0 -> p1: load on accept, otherwise drain when the consumer takes the beat
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            keep_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (s_valid && s_ready) begin
            vld_p1  <= 1'b1;
            data_p1 <= s_data;
            keep_p1 <= s_keep;
            last_p1 <= s_last;
        end else if (m_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign m_valid = vld_p1;
    assign m_data  = data_p1;
    assign m_keep  = keep_p1;
    assign m_last  = last_p1;

endmodule

// File: rtl/aes256_ctr_framer.sv
// Frames one key/IV config plus one plaintext packet into the cipher core stream:
// key low half, key high half, counter block, then payload beats.
module aes256_ctr_framer
    import aes_pkg::*;
#(
    parameter int BLOCK_SIZE = AES_BLOCK_SIZE,
    parameter int KEY_LENGTH = AES_KEY_LENGTH,
    parameter bit CHECK_KEEP = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Cfg_valid,
    output logic                    Cfg_ready,
    input  logic [KEY_LENGTH-1:0]   Cfg_key,
    input  logic [BLOCK_SIZE-1:0]   Cfg_iv,
    input  logic                    S_axis_tvalid,
    output logic                    S_axis_tready,
    input  logic [BLOCK_SIZE-1:0]   S_axis_tdata,
    input  logic [BLOCK_SIZE/8-1:0] S_axis_tkeep,
    input  logic                    S_axis_tlast,
    output logic                    M_axis_tvalid,
    input  logic                    M_axis_tready,
    output logic [BLOCK_SIZE-1:0]   M_axis_tdata,
    output logic [BLOCK_SIZE/8-1:0] M_axis_tkeep,
    output logic                    M_axis_tlast,
    output logic                    M_axis_tuser,
    output logic                    Busy,
    output logic                    Err_keep
);

    localparam int KEEP_W = BLOCK_SIZE / 8;
    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

    framer_state_t state, state_nxt;
    logic [KEY_LENGTH-1:0] key_q;
    logic [BLOCK_SIZE-1:0] iv_q;
    logic                  in_done;

    logic                  slc_s_valid, slc_s_ready, slc_m_ready;
    logic                  slc_m_valid, slc_m_last;
    logic [BLOCK_SIZE-1:0] slc_m_data;
    logic [KEEP_W-1:0]     slc_m_keep;
    logic                  s_hs, tail_hs;

    assign slc_s_valid   = (state == ST_DATA) && !in_done && S_axis_tvalid;
    assign slc_m_ready   = (state == ST_DATA) && M_axis_tready;
    assign S_axis_tready = (state == ST_DATA) && !in_done && slc_s_ready;
    assign s_hs          = S_axis_tvalid && S_axis_tready;
    assign tail_hs       = (state == ST_DATA) && slc_m_valid && slc_m_last && M_axis_tready;
    assign Busy          = (state != ST_IDLE);

    aes_axis_reg_slice #(
        .DATA_W (BLOCK_SIZE),
        .KEEP_W (KEEP_W)
    ) u_slice (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .s_valid (slc_s_valid),
        .s_ready (slc_s_ready),
        .s_data  (S_axis_tdata),
        .s_keep  (S_axis_tkeep),
        .s_last  (S_axis_tlast),
        .m_valid (slc_m_valid),
        .m_ready (slc_m_ready),
        .m_data  (slc_m_data),
        .m_keep  (slc_m_keep),
        .m_last  (slc_m_last)
    );

    always_comb begin
        state_nxt     = state;
        Cfg_ready     = 1'b0;
        M_axis_tvalid = 1'b0;
        M_axis_tdata  = '0;
        M_axis_tkeep  = '0;
        M_axis_tlast  = 1'b0;
        M_axis_tuser  = 1'b0;
        case (state)
            ST_IDLE: begin
                Cfg_ready = 1'b1;
                if (Cfg_valid) state_nxt = ST_KEY_LO;
            end
            ST_KEY_LO: begin
                M_axis_tvalid = 1'b1;
                M_axis_tdata  = key_q[BLOCK_SIZE-1:0];
                M_axis_tkeep  = KEEP_ALL;
                M_axis_tuser  = 1'b1;
                if (M_axis_tready) state_nxt = ST_KEY_HI;
            end
            ST_KEY_HI: begin
                M_axis_tvalid = 1'b1;
                M_axis_tdata  = key_q[KEY_LENGTH-1:BLOCK_SIZE];
                M_axis_tkeep  = KEEP_ALL;
                M_axis_tuser  = 1'b1;
                if (M_axis_tready) state_nxt = ST_CTR;
            end
            ST_CTR: begin
                M_axis_tvalid = 1'b1;
                M_axis_tdata  = iv_q;
                M_axis_tkeep  = KEEP_ALL;
                M_axis_tuser  = 1'b1;
                if (M_axis_tready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                M_axis_tvalid = slc_m_valid;
                M_axis_tdata  = slc_m_data;
                M_axis_tkeep  = slc_m_keep;
                M_axis_tlast  = slc_m_last;
                if (tail_hs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // in_done blocks further input once tlast is taken, until that beat leaves
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            key_q    <= '0;
            iv_q     <= '0;
            in_done  <= 1'b0;
            Err_keep <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && Cfg_valid) begin
                key_q <= Cfg_key;
                iv_q  <= Cfg_iv;
            end
            if (tail_hs)
                in_done <= 1'b0;
            else if (s_hs && S_axis_tlast)
                in_done <= 1'b1;
            Err_keep <= CHECK_KEEP && s_hs && !S_axis_tlast && (S_axis_tkeep != KEEP_ALL);
        end
    end

endmodule

// File: tb/tb_aes256_ctr_framer.sv
// Randomized bench for aes256_ctr_framer against a queue-based model of the output stream.
module tb_aes256_ctr_framer;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         Cfg_valid, Cfg_ready;
    logic [255:0] Cfg_key;
    logic [127:0] Cfg_iv;
    logic         S_axis_tvalid, S_axis_tready;
    logic [127:0] S_axis_tdata;
    logic [15:0]  S_axis_tkeep;
    logic         S_axis_tlast;
    logic         M_axis_tvalid, M_axis_tready;
    logic [127:0] M_axis_tdata;
    logic [15:0]  M_axis_tkeep;
    logic         M_axis_tlast, M_axis_tuser;
    logic         Busy, Err_keep;

    aes256_ctr_framer dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Cfg_valid     (Cfg_valid),
        .Cfg_ready     (Cfg_ready),
        .Cfg_key       (Cfg_key),
        .Cfg_iv        (Cfg_iv),
        .S_axis_tvalid (S_axis_tvalid),
        .S_axis_tready (S_axis_tready),
        .S_axis_tdata  (S_axis_tdata),
        .S_axis_tkeep  (S_axis_tkeep),
        .S_axis_tlast  (S_axis_tlast),
        .M_axis_tvalid (M_axis_tvalid),
        .M_axis_tready (M_axis_tready),
        .M_axis_tdata  (M_axis_tdata),
        .M_axis_tkeep  (M_axis_tkeep),
        .M_axis_tlast  (M_axis_tlast),
        .M_axis_tuser  (M_axis_tuser),
        .Busy          (Busy),
        .Err_keep      (Err_keep)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         user;
    } beat_t;

    beat_t        exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           m_mode = 0;
    bit           mon_en = 1'b1;
    bit           stall_prev = 1'b0;
    beat_t        held;
    bit           cfg_hs = 1'b0, s_hs = 1'b0, err_exp = 1'b0, pl_started = 1'b0;
    int           err_seen = 0, first_pl = 0, last_pl = 0;
    logic [255:0] hold_key;
    logic [127:0] hold_iv;

    task automatic check_val(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ckeep(input int nb);
        logic [16:0] t;
        t = (17'd1 << nb) - 17'd1;
        return t[15:0];
    endfunction

    // One clock: observe at the falling edge, then update M_axis_tready after the rising edge.
    task automatic step();
        beat_t cur, e;
        @(negedge Clk);
        cyc++;
        if (!Rst_n) begin
            stall_prev = 1'b0; err_exp = 1'b0; cfg_hs = 1'b0; s_hs = 1'b0;
        end else begin
            cur = {M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser};
            if (mon_en && stall_prev) begin
                check_val("stall_valid", M_axis_tvalid, 1);
                check_val("stall_beat", cur, held);
            end
            check_val("err_keep", Err_keep, err_exp);
            if (Err_keep) err_seen++;
            err_exp = S_axis_tvalid && S_axis_tready && !S_axis_tlast && (S_axis_tkeep != 16'hFFFF);
            cfg_hs  = Cfg_valid && Cfg_ready;
            s_hs    = S_axis_tvalid && S_axis_tready;
            if (mon_en && M_axis_tvalid && M_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_beat", cur, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("m_beat", cur, e);
                    if (!e.user) begin
                        if (!pl_started) begin first_pl = cyc; pl_started = 1'b1; end
                        last_pl = cyc;
                    end
                end
            end
            stall_prev = M_axis_tvalid && !M_axis_tready;
            held = cur;
        end
        @(posedge Clk);
        #1;
        case (m_mode)
            0: M_axis_tready = 1'b1;
            1: M_axis_tready = 1'($urandom % 2);
            2: M_axis_tready = ~M_axis_tready;
            default: M_axis_tready = 1'b0;
        endcase
    endtask

    task automatic cfg_start(input logic [255:0] key, input logic [127:0] iv);
        if (mon_en) begin
            exp_q.push_back({key[127:0], 16'hFFFF, 1'b0, 1'b1});
            exp_q.push_back({key[255:128], 16'hFFFF, 1'b0, 1'b1});
            exp_q.push_back({iv, 16'hFFFF, 1'b0, 1'b1});
        end
        Cfg_key = key; Cfg_iv = iv; Cfg_valid = 1'b1;
    endtask

    task automatic cfg_wait();
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = cfg_hs;
        end
        if (!got) check_val("cfg_timeout", 0, 1);
        Cfg_valid = 1'b0;
        pl_started = 1'b0;
    endtask

    // last_keep==0 picks a random contiguous keep for the final beat
    task automatic send_payload(input int n, input logic [15:0] last_keep, input int err_idx,
                                input bit gaps, input bit rnd_keep, input bit hold);
        beat_t b[$];
        beat_t x;
        bit    got;
        for (int i = 0; i < n; i++) begin
            x.data = {$urandom, $urandom, $urandom, $urandom};
            x.last = (i == n - 1);
            x.user = 1'b0;
            x.keep = 16'hFFFF;
            if (x.last) x.keep = (last_keep == 16'h0) ? ckeep(1 + int'($urandom % 16)) : last_keep;
            else if (rnd_keep && ($urandom % 4 == 0)) x.keep = ckeep(1 + int'($urandom % 15));
            if (i == err_idx) x.keep = 16'h7FFF;
            b.push_back(x);
            exp_q.push_back(x);
        end
        if (hold) cfg_start(hold_key, hold_iv);
        foreach (b[i]) begin
            if (gaps) begin
                S_axis_tvalid = 1'b0;
                repeat ($urandom % 3) step();
            end
            S_axis_tvalid = 1'b1;
            S_axis_tdata  = b[i].data;
            S_axis_tkeep  = b[i].keep;
            S_axis_tlast  = b[i].last;
            got = 1'b0;
            for (int k = 0; k < 300 && !got; k++) begin
                step();
                got = s_hs;
            end
            if (!got) check_val("s_timeout", 0, 1);
        end
        S_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            step();
            g++;
        end
        check_val("drain_left", exp_q.size(), 0);
        check_val("idle_cfg_ready", Cfg_ready, 1);
        check_val("idle_busy", Busy, 0);
        check_val("idle_m_valid", M_axis_tvalid, 0);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v = '0;
        for (int k = 0; k < 8; k++) v = {v[223:0], $urandom};
        return v;
    endfunction

    initial begin
        logic [255:0] k1, rk;
        logic [127:0] iv1, riv;
        int e0;
        Rst_n = 1'b0; Cfg_valid = 1'b0; Cfg_key = '0; Cfg_iv = '0;
        S_axis_tvalid = 1'b0; S_axis_tdata = '0; S_axis_tkeep = '0; S_axis_tlast = 1'b0;
        M_axis_tready = 1'b1;
        #12;
        check_val("rst_cfg_ready", Cfg_ready, 1);
        check_val("rst_m_valid", M_axis_tvalid, 0);
        check_val("rst_s_ready", S_axis_tready, 0);
        check_val("rst_busy", Busy, 0);
        check_val("rst_err", Err_keep, 0);
        check_val("rst_m_data", M_axis_tdata, 0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        repeat (2) step();

        // Fixed key 00..1F, IV F0..FF, single full beat
        k1 = '0; iv1 = '0;
        for (int i = 0; i < 32; i++) k1 = {k1[247:0], 8'(i)};
        for (int i = 0; i < 16; i++) iv1 = {iv1[119:0], 8'(8'hF0 + i)};
        m_mode = 0;
        cfg_start(k1, iv1); cfg_wait();
        send_payload(1, 16'hFFFF, -1, 1'b0, 1'b0, 1'b0);
        drain();

        // Three beats with a toggling consumer
        m_mode = 2;
        cfg_start(rnd256(), rnd256()); cfg_wait();
        send_payload(3, 16'h00FF, -1, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-to-back payload must leave the framer one beat per cycle
        m_mode = 0; step();
        cfg_start(rnd256(), rnd256()); cfg_wait();
        send_payload(8, 16'hFFFF, -1, 1'b0, 1'b0, 1'b0);
        drain();
        check_val("no_bubble_span", last_pl - first_pl, 7);

        // Short keep on a non-last beat
        e0 = err_seen;
        cfg_start(rnd256(), rnd256()); cfg_wait();
        send_payload(2, 16'hFFFF, 0, 1'b0, 1'b0, 1'b0);
        drain();
        repeat (2) step();
        check_val("err_pulses", err_seen - e0, 1);

        // Next config held valid while the current payload is in flight
        m_mode = 1;
        hold_key = rnd256(); hold_iv = rnd256();
        cfg_start(rnd256(), rnd256()); cfg_wait();
        send_payload(4, 16'h0000, -1, 1'b1, 1'b0, 1'b1);
        cfg_wait();
        send_payload(2, 16'h0000, -1, 1'b1, 1'b0, 1'b0);
        drain();

        // Reset while the high key half is on the output
        mon_en = 1'b0; m_mode = 0; step();
        rk = rnd256(); riv = rnd256();
        cfg_start(rk, riv); cfg_wait();
        m_mode = 3;
        step();
        check_val("keyhi_data", M_axis_tdata, rk[255:128]);
        check_val("keyhi_valid", M_axis_tvalid, 1);
        Rst_n = 1'b0;
        #1;
        check_val("midrst_m_valid", M_axis_tvalid, 0);
        check_val("midrst_cfg_ready", Cfg_ready, 1);
        check_val("midrst_busy", Busy, 0);
        repeat (2) step();
        Rst_n = 1'b1;
        m_mode = 0;
        step();
        check_val("postrst_cfg_ready", Cfg_ready, 1);
        check_val("postrst_m_valid", M_axis_tvalid, 0);
        mon_en = 1'b1;
        step();

        // Randomized packets
        for (int p = 0; p < 20; p++) begin
            m_mode = int'($urandom % 3);
            cfg_start(rnd256(), rnd256()); cfg_wait();
            send_payload(1 + int'($urandom % 6), 16'h0000, -1, 1'b1, 1'b1, 1'b0);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
